// File: rtl/ssd_pkg.sv
// Shared symbol and segment constants for the lock display path.
// Used by the scan driver and the combination-lock controller.
package ssd_pkg;

  typedef logic [4:0] sym_t;
  typedef logic [6:0] seg_t;

  localparam sym_t SYM_O     = 5'd0;
  localparam sym_t SYM_S     = 5'd5;
  localparam sym_t SYM_C     = 5'd12;
  localparam sym_t SYM_E     = 5'd14;
  localparam sym_t SYM_L     = 5'd16;
  localparam sym_t SYM_D     = 5'd17;
  localparam sym_t SYM_P     = 5'd18;
  localparam sym_t SYM_N     = 5'd19;
  localparam sym_t SYM_DASH  = 5'd20;
  localparam sym_t SYM_BLANK = 5'd21;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  localparam logic [19:0] CODE_ALL_BLANK =
    {SYM_BLANK, SYM_BLANK, SYM_BLANK, SYM_BLANK};

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_sel(input logic [1:0] d);
    logic [3:0] a;
    a = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_code_to_segment.sv
// Symbol code to active-low {g,f,e,d,c,b,a} segment decoder.
// Purely combinational; unknown codes render blank.
module code_to_segment
  import ssd_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  // Table lookup of the glyph for each symbol code.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:      seg = 7'b1000000;
      5'd1:      seg = 7'b1111001;
      5'd2:      seg = 7'b0100100;
      5'd3:      seg = 7'b0110000;
      5'd4:      seg = 7'b0011001;
      5'd5:      seg = 7'b0010010;
      5'd6:      seg = 7'b0000010;
      5'd7:      seg = 7'b1111000;
      5'd8:      seg = 7'b0000000;
      5'd9:      seg = 7'b0010000;
      5'd10:     seg = 7'b0001000;
      5'd11:     seg = 7'b0000011;
      5'd12:     seg = 7'b1000110;
      5'd13:     seg = 7'b0100001;
      5'd14:     seg = 7'b0000110;
      5'd15:     seg = 7'b0001110;
      SYM_L:     seg = 7'b1000111;
      SYM_D:     seg = 7'b0100001;
      SYM_P:     seg = 7'b0001100;
      SYM_N:     seg = 7'b0101011;
      SYM_DASH:  seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame latching.
// Define SSD_BLINK_EN to enable per-digit blinking via blink_mask.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd_code,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int SW = $clog2(SCAN_DIV);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_sel;
  logic          load_pend;
  logic [19:0]   code_q;
  logic          scan_wrap;
  logic [4:0]    cur_code;
  logic [6:0]    dec_seg;
  logic          blank_cur;

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  // Digit dwell counter; idles during the post-reset load cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd3;
      load_pend <= 1'b1;
    end else begin
      load_pend <= 1'b0;
      if (!load_pend) begin
        if (scan_wrap) begin
          scan_cnt  <= '0;
          digit_sel <= digit_sel - 2'd1;
        end else begin
          scan_cnt <= scan_cnt + SW'(1);
        end
      end
    end
  end

  // Frame shadow: reload only when entering digit 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= CODE_ALL_BLANK;
    end else if (load_pend || (scan_wrap && digit_sel == 2'd0)) begin
      code_q <= ssd_code;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    mask_q;

  // Free-running blink half-period timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Mask shadow shares the frame boundary with the codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 4'b0000;
    end else if (load_pend || (scan_wrap && digit_sel == 2'd0)) begin
      mask_q <= blink_mask;
    end
  end

  assign blank_cur = !blink_phase && mask_q[digit_sel];
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_mask;
  assign unused_mask = ^blink_mask;
  assign blank_cur   = 1'b0;
`endif

  // Pick the symbol for the digit being scanned.
  always_comb begin
    cur_code = SYM_BLANK;
    case (digit_sel)
      2'd3: cur_code = code_q[19:15];
      2'd2: cur_code = code_q[14:10];
      2'd1: cur_code = code_q[9:5];
      2'd0: cur_code = code_q[4:0];
      default: cur_code = SYM_BLANK;
    endcase
  end

  code_to_segment u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

  // Registered pin drivers; dark until the first frame is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else if (load_pend) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
    end else begin
      seg <= blank_cur ? SEG_BLANK : dec_seg;
      an  <= an_sel(digit_sel);
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with SCAN_DIV=4, BLINK_DIV=32.
// Expected pin values are stamped with the cycle they must appear in.
module tb_ssd_scan_driver;

  logic        clk;
  logic        rst;
  logic [19:0] ssd_code;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  an;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];

  ssd_scan_driver #(
    .SCAN_DIV  (4),
    .BLINK_DIV (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ssd_code   (ssd_code),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] exp_seg(input logic [4:0] c);
    case (c)
      5'd0:  return 7'b1000000;
      5'd5:  return 7'b0010010;
      5'd12: return 7'b1000110;
      5'd14: return 7'b0000110;
      5'd16: return 7'b1000111;
      5'd17: return 7'b0100001;
      5'd18: return 7'b0001100;
      5'd19: return 7'b0101011;
      5'd20: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic void push(input int c, input logic [3:0] a,
                               input logic [6:0] s);
    exp_t e;
    e.cyc = c;
    e.an  = a;
    e.seg = s;
    q.push_back(e);
  endfunction

  // Monitor: compare DUT pins against the entry due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missed cyc=%0d got none, required an=%b seg=%b",
               e.cyc, e.an, e.seg);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_chk++;
      if (an !== e.an || seg !== e.seg) begin
        n_fail++;
        $display("FAIL scan cyc=%0d got an=%b seg=%b required an=%b seg=%b",
                 cyc, an, seg, e.an, e.seg);
      end
    end
  end

  // Reset mid-scan, release with c0/m0, optionally swap to c1 after
  // cycle rel+chg, and expect nfr full frames.
  task automatic scen(input logic [19:0] c0, input logic [3:0] m0,
                      input logic [19:0] c1, input int chg,
                      input int nfr);
    int rel;
    logic [19:0] fc;
    logic [6:0]  s;
    logic [4:0]  sym;
    @(posedge clk);
    #3;
    rst        = 1'b1;
    ssd_code   = c0;
    blink_mask = m0;
    push(cyc, 4'b1111, 7'b1111111);
    repeat (2) begin
      @(posedge clk);
      #3;
      push(cyc, 4'b1111, 7'b1111111);
    end
    rst = 1'b0;
    rel = cyc;
    push(rel + 1, 4'b1111, 7'b1111111);
    for (int m = 2; m < 2 + 16 * nfr; m++) begin
      int slot;
      int d;
      int f;
      slot = (m - 2) / 4;
      d    = 3 - (slot % 4);
      f    = slot / 4;
      fc   = (chg > 0 && 1 + 16 * f > chg) ? c1 : c0;
      sym  = fc[d*5 +: 5];
      s    = exp_seg(sym);
`ifdef SSD_BLINK_EN
      if (m0[d] && (((m - 1) / 32) % 2) == 1)
        s = 7'b1111111;
`endif
      push(rel + m, ~(4'b0001 << d), s);
    end
    while (cyc < rel + 16 * nfr + 6) begin
      @(posedge clk);
      #3;
      if (chg > 0 && cyc == rel + chg)
        ssd_code = c1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    ssd_code   = '0;
    blink_mask = 4'b0000;
    // {C,L,5,d}, no blink
    scen({5'd12, 5'd16, 5'd5, 5'd17}, 4'b0000,
         {5'd12, 5'd16, 5'd5, 5'd17}, 0, 2);
    // {0,E,P,n} then {C,L,5,d} during digit 1's slot
    scen({5'd0, 5'd14, 5'd18, 5'd19}, 4'b0000,
         {5'd12, 5'd16, 5'd5, 5'd17}, 11, 2);
    // {5,DASH,BLANK,BLANK}, digit 3 blinks
    scen({5'd5, 5'd20, 5'd21, 5'd21}, 4'b1000,
         {5'd5, 5'd20, 5'd21, 5'd21}, 0, 8);
    // out-of-range codes, all digits masked
    scen({5'd22, 5'd31, 5'd20, 5'd0}, 4'b1111,
         {5'd22, 5'd31, 5'd20, 5'd0}, 0, 5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain got %0d pending, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed four-digit seven-segment display driver, downstream of the combination-lock controller. It consumes the controller's 20-bit display word (four 5-bit symbol codes) plus a per-digit blink mask. It drives the board's shared active-low segment bus and digit anodes, scanning one digit at a time. It also generates the 1 Hz blink used while a password digit is being entered.

## Interface
- SCAN_DIV, 50_000: clk cycles each digit stays lit (1 ms at 50 MHz).
- BLINK_DIV, 25_000_000: clk cycles per blink half-period (1 Hz at 50 MHz).
- clk input 1: system clock.
- rst input 1: reset, asynchronous, active-high.
- ssd_code input 20: display codes.
  - [19:15] = digit 3 (leftmost), [14:10] = digit 2, [9:5] = digit 1, [4:0] = digit 0.
- blink_mask input 4: bit i set means digit i blinks.
- seg output 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- an output 4: digit anodes, active-low, one-hot-low, registered; an[3] is the leftmost digit.

## Operation
- Symbol codes:
  - 0–15 are hex digits 0–F. This covers C=12, S=5, O=0, E=14.
  - 16 L, 17 d, 18 P, 19 n, 20 DASH, 21 BLANK.
  - Codes 22–31 display blank.
- Required encodings:
  - 0 → 1000000
  - 5 → 0010010
  - C → 1000110
  - E → 0000110
  - L → 1000111
  - d → 0100001
  - P → 0001100
  - n → 0101011
  - DASH → 0111111
  - BLANK → 1111111
- Scan order: digit 3, 2, 1, 0, 3, … Each digit is held for exactly SCAN_DIV cycles.
- Frame latch: ssd_code and blink_mask are captured into shadow registers only when the scan advances into digit 3, and once out of reset. A frame therefore never mixes old and new codes.
- Blink:
  - blink_phase starts at 1 (visible) and toggles every BLINK_DIV cycles, free-running, independent of the scan.
  - When blink_phase=0 and the latched mask bit for the current digit is 1, seg = 1111111.
  - In that case an still selects the digit.
- Counters:
  - scan_cnt is ceil(log2(SCAN_DIV)) bits and wraps SCAN_DIV-1 → 0.
  - blink_cnt is ceil(log2(BLINK_DIV)) bits and wraps the same way.
  - A count of zero is never reached with SCAN_DIV or BLINK_DIV < 2; both parameters must be ≥ 2.
- Mask changes mid-frame take effect at the next frame.

## Timing
- Reset (asynchronous):
  - Outputs: an=1111, seg=1111111.
  - Internal state: scan_cnt=0, blink_cnt=0, digit_sel=3, blink_phase=1, shadows=BLANK codes with mask 0000.
- First rising edge after rst deasserts:
  - Shadows load ssd_code/blink_mask.
  - The following edge drives an=0111 with digit 3 segments.
  - Outputs are registered, so seg/an lag digit_sel by one cycle.
- Input-to-display latency: at most 4·SCAN_DIV+2 cycles.
- rst asserted mid-frame returns all state to reset values within the same cycle. No partial frame persists.
- Simultaneous scan wrap and blink toggle in one cycle: both apply. The segment value uses the new blink_phase from the next cycle.

## Configuration
- SSD_BLINK_EN defined: blink counter and masking as described.
- SSD_BLINK_EN undefined:
  - blink_cnt and blink_phase are removed and blink_mask is ignored.
  - Digits are always shown.
  - BLINK_DIV is unused.

## Structure
- Shared package ssd_pkg:
  - 5-bit symbol code constants (SYM_L, SYM_D, SYM_P, SYM_N, SYM_DASH, SYM_BLANK, plus the hex codes used by the lock: SYM_C, SYM_S, SYM_O, SYM_E).
  - 7-bit segment constants SEG_BLANK and SEG_DASH.
  - The lock controller uses the same package.
- Sub-module code_to_segment: purely combinational 5-bit code to 7-bit active-low segment decoder, one instance on the selected digit.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_DIV=32.
- Reset, then hold rst: an=1111 and seg=1111111 while rst is high. After release, the sequence an=0111,1011,1101,1110 repeats with 4 cycles per digit.
- ssd_code={C,L,5,d} with mask 0000: seg steps through 1000110, 1000111, 0010010, 0100001 in step with an.
- ssd_code changed in the middle of digit 1's slot:
  - Digits 1 and 0 of the current frame still show the old codes.
  - The new codes appear from the next an=0111.
- mask=1000 with {5,DASH,BLANK,BLANK} (SSD_BLINK_EN defined):
  - Digit 3 shows 0010010 for 32 cycles, then 1111111 for 32 cycles, alternating.
  - Digit 2 shows 0111111 continuously.
- Codes 22 and 31: seg=1111111.
- Assert rst for one cycle mid-scan: outputs immediately 1111/1111111 and the scan restarts at digit 3. Rebuilt without SSD_BLINK_EN, mask=1111 gives no blanking.
